sync_split: RTL and testbench

SYNC_SPLIT -- requirements
Module: sync_split

---
 rtl/sync_split_if.sv | 20 ++
 rtl/sync_split.sv | 143 ++++++++++++++
 tb/tb_sync_split.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/sync_split_if.sv
// rtl/sync_split_if.sv - request/response bundle between one master, the splitter and its slaves
interface sync_split_if #(
    parameter int N_SLAVES = 2,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32
);
    // Request  = {valid, addr, wdata, wstrb}; response = {rdata, ready}.
    // Slave k occupies slice k of s_req / s_resp.
    localparam int REQ_W  = 1 + ADDR_W + DATA_W + DATA_W / 8;
    localparam int RESP_W = DATA_W + 1;

    logic [REQ_W-1:0]           m_req;
    logic [RESP_W-1:0]          m_resp;
    logic [N_SLAVES*REQ_W-1:0]  s_req;
    logic [N_SLAVES*RESP_W-1:0] s_resp;

    modport master (output m_req, input m_resp);
    modport slave  (input s_req, output s_resp);
    modport split  (input m_req, output m_resp, output s_req, input s_resp);
endinterface

// File: rtl/sync_split.sv
// rtl/sync_split.sv - address-decoded 1:N request splitter with zero-wait pass-through and decode-error reply
module sync_split #(
    parameter int N_SLAVES = 2,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int P_SLAVES = ADDR_W - 1
) (
    input  logic         clk,
    input  logic         rst,
    sync_split_if.split  bus,
    output logic         busy,
    output logic         dec_err
);

    localparam int S_W       = $clog2(N_SLAVES);
    localparam int STRB_W    = DATA_W / 8;
    localparam int REQ_W     = 1 + ADDR_W + DATA_W + STRB_W;
    localparam int RESP_W    = DATA_W + 1;
    localparam int VALID_BIT = REQ_W - 1;
    localparam int ADDR_LSB  = DATA_W + STRB_W;
    localparam bit SEL_FULL  = ((1 << S_W) == N_SLAVES);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_ERR  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [S_W-1:0]    sel_q, sel_d;

    logic              m_valid;
    logic [S_W-1:0]    sel_dec;
    logic              sel_ok;
    logic [S_W-1:0]    act_sel;
    logic [RESP_W-1:0] act_resp;
    logic              act_ready;
    logic              route_en;

    assign m_valid = bus.m_req[VALID_BIT];
    assign sel_dec = bus.m_req[ADDR_LSB + P_SLAVES -: S_W];

    // With a power-of-two slave count every encoding of the select field is a real slave.
    generate
        if (SEL_FULL) begin : g_sel_full
            assign sel_ok = 1'b1;
        end else begin : g_sel_part
            assign sel_ok = ({1'b0, sel_dec} < (S_W + 1)'(N_SLAVES));
        end
    endgenerate

    // Once a transaction is waiting, routing is pinned to the latched slave.
    always_comb begin
        act_sel = (state_q == ST_BUSY) ? sel_q : sel_dec;
    end

    always_comb begin
        act_resp = '0;
        for (int k = 0; k < N_SLAVES; k++) begin
            if (act_sel == S_W'(k)) begin
                act_resp = bus.s_resp[k*RESP_W +: RESP_W];
            end
        end
    end

    assign act_ready = act_resp[0];

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        route_en = 1'b0;
        busy     = 1'b0;
        dec_err  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (m_valid) begin
                    if (sel_ok) begin
                        route_en = 1'b1;
                        if (!act_ready) begin
                            state_d = ST_BUSY;
                            sel_d   = sel_dec;
                        end
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_BUSY: begin
                busy = 1'b1;
                // Dropping valid mid-transaction abandons it without a reply.
                if (m_valid) begin
                    route_en = 1'b1;
                    if (act_ready) begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERR: begin
                busy    = 1'b1;
                dec_err = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (rst) begin
            route_en = 1'b0;
            busy     = 1'b0;
            dec_err  = 1'b0;
        end
    end

    always_comb begin
        bus.s_req = '0;
        for (int k = 0; k < N_SLAVES; k++) begin
            if (route_en && (act_sel == S_W'(k))) begin
                bus.s_req[k*REQ_W +: REQ_W] = bus.m_req;
            end
        end
    end

    always_comb begin
        if (route_en) begin
            bus.m_resp = act_resp;
        end else if (dec_err) begin
            bus.m_resp = {{DATA_W{1'b0}}, 1'b1};
        end else begin
            bus.m_resp = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

endmodule

// File: tb/tb_sync_split.sv
// tb/tb_sync_split.sv - directed vector bench for sync_split with three slaves and 16-bit addresses
module tb_sync_split;

    localparam int NS     = 3;
    localparam int DW     = 32;
    localparam int AW     = 16;
    localparam int REQ_W  = 1 + AW + DW + DW / 8;
    localparam int RESP_W = DW + 1;

    logic clk;
    logic rst;
    logic busy;
    logic dec_err;

    sync_split_if #(.N_SLAVES(NS), .DATA_W(DW), .ADDR_W(AW)) bus ();

    sync_split #(
        .N_SLAVES (NS),
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .P_SLAVES (15)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .busy    (busy),
        .dec_err (dec_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        mv;
        logic [15:0] addr;
        logic [2:0]  rdy;
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [2:0]  e_sv;
        logic        e_rdy;
        logic [31:0] e_rd;
        logic        e_busy;
        logic        e_derr;
    } vec_t;

    vec_t vecs[$];
    int   checks;
    int   failures;
    int   cur;

    task automatic addv(input logic r, input logic mv, input logic [15:0] addr,
                        input logic [2:0] rdy, input logic [31:0] rd0, input logic [31:0] rd1,
                        input logic [31:0] rd2, input logic [2:0] e_sv, input logic e_rdy,
                        input logic [31:0] e_rd, input logic e_busy, input logic e_derr);
        vec_t v;
        v.rst = r; v.mv = mv; v.addr = addr; v.rdy = rdy;
        v.rd0 = rd0; v.rd1 = rd1; v.rd2 = rd2;
        v.e_sv = e_sv; v.e_rdy = e_rdy; v.e_rd = e_rd;
        v.e_busy = e_busy; v.e_derr = e_derr;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step %0d: got %h expected %h", name, cur, act, exp);
        end
    endtask

    function automatic logic [REQ_W-1:0] mk_req(input logic mv, input logic [15:0] addr);
        logic [31:0] wd;
        wd = 32'hC0DE_0000 | {16'h0000, addr};
        return {mv, addr, wd, 4'hF};
    endfunction

    task automatic drive(input logic r, input logic mv, input logic [15:0] addr, input logic [2:0] rdy,
                         input logic [31:0] rd0, input logic [31:0] rd1, input logic [31:0] rd2);
        rst        = r;
        bus.m_req  = mk_req(mv, addr);
        bus.s_resp = {rd2, rdy[2], rd1, rdy[1], rd0, rdy[0]};
    endtask

    function automatic logic [2:0] sv_bits();
        logic [2:0] b;
        for (int k = 0; k < NS; k++) b[k] = bus.s_req[k*REQ_W + REQ_W - 1];
        return b;
    endfunction

    initial begin
        logic [REQ_W-1:0] exp_req;
        logic             seen;
        int               lat;
        logic             onehot_ok;
        logic             busy_ok;

        checks   = 0;
        failures = 0;
        cur      = 0;
        rst        = 1'b1;
        bus.m_req  = '0;
        bus.s_resp = '0;

        //    rst mv  addr      rdy     rd0           rd1           rd2           e_sv    rdy e_rd          busy derr
        // reset overrides live inputs
        addv(1, 1, 16'h4010, 3'b010, 32'h0,        32'hA5A5A5A5, 32'h0,        3'b000, 0, 32'h0,        0, 0);
        addv(0, 0, 16'h0000, 3'b000, 32'h0,        32'h0,        32'h0,        3'b000, 0, 32'h0,        0, 0);
        // zero-wait read from slave 1
        addv(0, 1, 16'h4010, 3'b010, 32'h0,        32'hA5A5A5A5, 32'h0,        3'b010, 1, 32'hA5A5A5A5, 0, 0);
        // slave 2 with three wait cycles
        addv(0, 1, 16'h8004, 3'b000, 32'h0,        32'h0,        32'h0,        3'b100, 0, 32'h0,        0, 0);
        addv(0, 1, 16'h8004, 3'b000, 32'h0,        32'h0,        32'h0,        3'b100, 0, 32'h0,        1, 0);
        addv(0, 1, 16'h8004, 3'b000, 32'h0,        32'h0,        32'h0,        3'b100, 0, 32'h0,        1, 0);
        addv(0, 1, 16'h8004, 3'b100, 32'h0,        32'h0,        32'h12345678, 3'b100, 1, 32'h12345678, 1, 0);
        addv(0, 0, 16'h0000, 3'b000, 32'h0,        32'h0,        32'h0,        3'b000, 0, 32'h0,        0, 0);
        // routing hold toward slave 0 while the address moves to slave 1
        addv(0, 1, 16'h0000, 3'b000, 32'h0,        32'h0,        32'h0,        3'b001, 0, 32'h0,        0, 0);
        addv(0, 1, 16'h4000, 3'b010, 32'h0,        32'hDEADBEEF, 32'h0,        3'b001, 0, 32'h0,        1, 0);
        addv(0, 1, 16'h4000, 3'b011, 32'h0BADF00D, 32'hDEADBEEF, 32'h0,        3'b001, 1, 32'h0BADF00D, 1, 0);
        addv(0, 1, 16'h4000, 3'b010, 32'h0,        32'hDEADBEEF, 32'h0,        3'b010, 1, 32'hDEADBEEF, 0, 0);
        // decode error
        addv(0, 1, 16'hC000, 3'b111, 32'h11111111, 32'h22222222, 32'h33333333, 3'b000, 0, 32'h0,        0, 0);
        addv(0, 1, 16'hC000, 3'b111, 32'h11111111, 32'h22222222, 32'h33333333, 3'b000, 1, 32'h0,        1, 1);
        addv(0, 0, 16'h0000, 3'b000, 32'h0,        32'h0,        32'h0,        3'b000, 0, 32'h0,        0, 0);
        // abort by dropping valid in BUSY
        addv(0, 1, 16'h8004, 3'b000, 32'h0,        32'h0,        32'h0,        3'b100, 0, 32'h0,        0, 0);
        addv(0, 1, 16'h8004, 3'b000, 32'h0,        32'h0,        32'h0,        3'b100, 0, 32'h0,        1, 0);
        addv(0, 0, 16'h8004, 3'b100, 32'h0,        32'h0,        32'h55555555, 3'b000, 0, 32'h0,        1, 0);
        addv(0, 0, 16'h8004, 3'b100, 32'h0,        32'h0,        32'h55555555, 3'b000, 0, 32'h0,        0, 0);
        // reset mid-BUSY, late ready ignored
        addv(0, 1, 16'h4010, 3'b000, 32'h0,        32'h0,        32'h0,        3'b010, 0, 32'h0,        0, 0);
        addv(0, 1, 16'h4010, 3'b000, 32'h0,        32'h0,        32'h0,        3'b010, 0, 32'h0,        1, 0);
        addv(1, 1, 16'h4010, 3'b010, 32'h0,        32'h77777777, 32'h0,        3'b000, 0, 32'h0,        0, 0);
        addv(0, 0, 16'h4010, 3'b010, 32'h0,        32'h77777777, 32'h0,        3'b000, 0, 32'h0,        0, 0);
        // reset mid-ERR
        addv(0, 1, 16'hC000, 3'b000, 32'h0,        32'h0,        32'h0,        3'b000, 0, 32'h0,        0, 0);
        addv(1, 1, 16'hC000, 3'b000, 32'h0,        32'h0,        32'h0,        3'b000, 0, 32'h0,        0, 0);
        addv(0, 0, 16'h0000, 3'b000, 32'h0,        32'h0,        32'h0,        3'b000, 0, 32'h0,        0, 0);
        // back-to-back zero-wait to slave 0 then slave 2
        addv(0, 1, 16'h0000, 3'b001, 32'h00000001, 32'h0,        32'h0,        3'b001, 1, 32'h00000001, 0, 0);
        addv(0, 1, 16'h8004, 3'b100, 32'h0,        32'h0,        32'h00000002, 3'b100, 1, 32'h00000002, 0, 0);
        addv(0, 0, 16'h0000, 3'b000, 32'h0,        32'h0,        32'h0,        3'b000, 0, 32'h0,        0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            cur = i;
            drive(vecs[i].rst, vecs[i].mv, vecs[i].addr, vecs[i].rdy,
                  vecs[i].rd0, vecs[i].rd1, vecs[i].rd2);
            #1;
            chk("s_req_valid", 64'(sv_bits()), 64'(vecs[i].e_sv));
            chk("m_resp", 64'(bus.m_resp), 64'({vecs[i].e_rd, vecs[i].e_rdy}));
            chk("busy", 64'(busy), 64'(vecs[i].e_busy));
            chk("dec_err", 64'(dec_err), 64'(vecs[i].e_derr));
            for (int k = 0; k < NS; k++) begin
                exp_req = vecs[i].e_sv[k] ? mk_req(vecs[i].mv, vecs[i].addr) : '0;
                chk($sformatf("s_req%0d_payload", k), 64'(bus.s_req[k*REQ_W +: REQ_W]), 64'(exp_req));
            end
        end

        // Slave 1 answers after five wait cycles; the wait is bounded.
        cur       = 1000;
        seen      = 1'b0;
        lat       = -1;
        onehot_ok = 1'b1;
        busy_ok   = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            drive(1'b0, 1'b1, 16'h4ABC, (n == 5) ? 3'b010 : 3'b000,
                  32'h0, (n == 5) ? 32'h600DCAFE : 32'h0, 32'h0);
            #1;
            if (sv_bits() != 3'b010) onehot_ok = 1'b0;
            if (busy !== (n != 0)) busy_ok = 1'b0;
            if (bus.m_resp[0] === 1'b1) begin
                seen = 1'b1;
                lat  = n;
                chk("hs_rdata", 64'(bus.m_resp[RESP_W-1:1]), 64'h600DCAFE);
                break;
            end
        end
        chk("hs_ready_seen", 64'(seen), 64'd1);
        chk("hs_latency", 64'(lat), 64'd5);
        chk("hs_route_slave1_only", 64'(onehot_ok), 64'd1);
        chk("hs_busy_profile", 64'(busy_ok), 64'd1);
        @(negedge clk);
        drive(1'b0, 1'b0, 16'h0000, 3'b000, 32'h0, 32'h0, 32'h0);
        #1;
        chk("hs_idle_after", 64'({busy, bus.m_resp}), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
